// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared types and helpers for the multi-port register file.
//   pc_sel_e : next-PC source selector driven by fetch/branch control
//   f_aw     : register address width for a given register count
package regfile_pkg;

  typedef enum logic [1:0] {
    PC_INC   = 2'd0,
    PC_DP    = 2'd1,
    PC_START = 2'd2,
    PC_HOLD  = 2'd3
  } pc_sel_e;

  function automatic int f_aw(input int nregs);
    return (nregs > 2) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Load-pending scoreboard: one busy bit per architectural register.
//   Ports:
//     clk, rst        clock, async active-high reset
//     sb_set/sb_addr  mark a register load-pending at the edge
//     clr_en/clr_addr LDR return write, clears the pending bit at the edge
//     busy            registered busy vector
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS   = 16,
  parameter int AW      = 4,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sb_set,
  input  logic [AW-1:0]    sb_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busy_d;

  // Set is applied after clear so a new load issued in the same cycle as
  // an older load's return keeps the register pending.
  always_comb begin
    busy_d = busy;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (sb_set) busy_d[sb_addr] = 1'b1;
    if (ZERO_R0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_d;
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
//   Parametrised multi-port register file with write-to-read bypass,
//   load-pending scoreboard and integrated program counter.
//   Ports:
//     clk, rst          clock, async active-high reset
//     w_en/w_addr/w_data  NWR write ports, port NWR-1 is the LDR return
//     rd_addr/rd_data     NRD combinational read ports
//     rd_busy             per read port: addressed register has a load pending
//     sb_set/sb_addr      scoreboard set request
//     busy                scoreboard vector
//     load_pc/sel_pc      PC update enable and source (pc_sel_e)
//     start_pc/dp_pc      reset-vector and branch-target sources
//     pc_out              current PC
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 16,
  parameter int NWR      = 3,
  parameter int NRD      = 5,
  parameter int PC_W     = 11,
  parameter bit ZERO_R0  = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter bit PC_ALIAS = 1'b1,
  localparam int AW      = f_aw(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWR-1:0]        w_en,
  input  logic [NWR*AW-1:0]     w_addr,
  input  logic [NWR*DATA_W-1:0] w_data,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  sb_set,
  input  logic [AW-1:0]         sb_addr,
  output logic [NREGS-1:0]      busy,
  input  logic                  load_pc,
  input  logic [1:0]            sel_pc,
  input  logic [PC_W-1:0]       start_pc,
  input  logic [PC_W-1:0]       dp_pc,
  output logic [PC_W-1:0]       pc_out
);

  logic [DATA_W-1:0] regs   [NREGS];
  logic [DATA_W-1:0] wr_val [NREGS];
  logic [NREGS-1:0]  wr_hit;
  logic [NREGS-1:0]  wr_we;
  logic [AW-1:0]     ra;
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   pc_d;

  // Per-register write decode. Ports are scanned in ascending order so the
  // highest enabled port (the LDR return) wins a collision.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      wr_hit[r] = 1'b0;
      wr_val[r] = '0;
      for (int p = 0; p < NWR; p++) begin
        if (w_en[p] && (w_addr[p*AW +: AW] == AW'(r))) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = w_data[p*DATA_W +: DATA_W];
        end
      end
      wr_we[r] = wr_hit[r] && !(ZERO_R0 && (r == 0)) && !(PC_ALIAS && (r == NREGS - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++)
        if (wr_we[r]) regs[r] <= wr_val[r];
    end
  end

  // Read muxes. R0 and the PC alias take precedence so bypass never
  // forwards data for an address that cannot be written.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = rd_addr[i*AW +: AW];
      if (ZERO_R0 && (ra == '0))
        rd_data[i*DATA_W +: DATA_W] = '0;
      else if (PC_ALIAS && (ra == AW'(NREGS - 1)))
        rd_data[i*DATA_W +: DATA_W] = DATA_W'(pc_q);
      else if (BYPASS && wr_we[ra])
        rd_data[i*DATA_W +: DATA_W] = wr_val[ra];
      else
        rd_data[i*DATA_W +: DATA_W] = regs[ra];
      // Busy is deliberately not bypassed by a same-cycle LDR clear.
      rd_busy[i] = busy[ra];
    end
  end

  regfile_scoreboard #(
    .NREGS   (NREGS),
    .AW      (AW),
    .ZERO_R0 (ZERO_R0)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .clr_en   (w_en[NWR-1]),
    .clr_addr (w_addr[(NWR-1)*AW +: AW]),
    .busy     (busy)
  );

  always_comb begin
    pc_d = pc_q;
    if (load_pc) begin
      case (pc_sel_e'(sel_pc))
        PC_INC:   pc_d = pc_q + PC_W'(1);
        PC_DP:    pc_d = dp_pc;
        PC_START: pc_d = start_pc;
        PC_HOLD:  pc_d = pc_q;
        default:  pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= '0;
    else     pc_q <= pc_d;
  end

  assign pc_out = pc_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
//   Scoreboard bench for regfile_mp. A default build (bypass on) and a
//   bypass-off build share all inputs; expected outputs come from an
//   array-based register model and are checked by a separate monitor.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int AW = 4;
  localparam int NW = 3;
  localparam int ND = 5;
  localparam int PW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NW-1:0]    w_en;
  logic [NW*AW-1:0] w_addr;
  logic [NW*DW-1:0] w_data;
  logic [ND*AW-1:0] rd_addr;
  logic [ND*DW-1:0] rd_data, rd_data_nb;
  logic [ND-1:0]    rd_busy, rd_busy_nb;
  logic             sb_set;
  logic [AW-1:0]    sb_addr;
  logic [NR-1:0]    busy, busy_nb;
  logic             load_pc;
  logic [1:0]       sel_pc;
  logic [PW-1:0]    start_pc, dp_pc, pc_out, pc_out_nb;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .sb_set(sb_set), .sb_addr(sb_addr), .busy(busy),
    .load_pc(load_pc), .sel_pc(sel_pc), .start_pc(start_pc), .dp_pc(dp_pc),
    .pc_out(pc_out)
  );

  regfile_mp #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .sb_set(sb_set), .sb_addr(sb_addr), .busy(busy_nb),
    .load_pc(load_pc), .sel_pc(sel_pc), .start_pc(start_pc), .dp_pc(dp_pc),
    .pc_out(pc_out_nb)
  );

  // Reference model state
  logic [DW-1:0] m_reg [NR];
  logic [NR-1:0] m_busy;
  logic [PW-1:0] m_pc;

  typedef struct {
    string          tag;
    logic [ND*DW-1:0] rd;
    logic [ND*DW-1:0] rd_nb;
    logic [ND-1:0]  rdb;
    logic [NR-1:0]  busy;
    logic [PW-1:0]  pc;
    bit             lit_rd_en;
    logic [DW-1:0]  lit_rd;
    bit             lit_pc_en;
    logic [PW-1:0]  lit_pc;
  } exp_t;

  exp_t exp_q[$];

  // Optional hand-written expectations for port 0 data and pc this cycle
  bit            lit_rd_en = 1'b0;
  logic [DW-1:0] lit_rd    = '0;
  bit            lit_pc_en = 1'b0;
  logic [PW-1:0] lit_pc    = '0;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, want);
  endtask

  function automatic logic [DW-1:0] model_read(input int a, input bit byp);
    logic [DW-1:0] v;
    bit hit;
    if (a == 0) return '0;
    if (a == NR - 1) return {{(DW-PW){1'b0}}, m_pc};
    hit = 1'b0;
    v   = '0;
    if (byp) begin
      for (int p = 0; p < NW; p++)
        if (w_en[p] && int'(w_addr[p*AW +: AW]) == a) begin
          hit = 1'b1;
          v   = w_data[p*DW +: DW];
        end
    end
    return hit ? v : m_reg[a];
  endfunction

  task automatic model_update();
    int a;
    for (int p = 0; p < NW; p++) begin
      a = int'(w_addr[p*AW +: AW]);
      if (w_en[p] && a != 0 && a != NR - 1) m_reg[a] = w_data[p*DW +: DW];
    end
    if (w_en[NW-1]) m_busy[w_addr[(NW-1)*AW +: AW]] = 1'b0;
    if (sb_set) m_busy[sb_addr] = 1'b1;
    m_busy[0] = 1'b0;
    if (load_pc) begin
      case (sel_pc)
        PC_INC:   m_pc = m_pc + 1'b1;
        PC_DP:    m_pc = dp_pc;
        PC_START: m_pc = start_pc;
        default:  m_pc = m_pc;
      endcase
    end
  endtask

  // Called at posedge+1: queue this cycle's expectation, cross the edge,
  // advance the model with the inputs that were sampled.
  task automatic step(input string tag);
    exp_t e;
    int a;
    e.tag = tag;
    for (int i = 0; i < ND; i++) begin
      a = int'(rd_addr[i*AW +: AW]);
      e.rd[i*DW +: DW]    = model_read(a, 1'b1);
      e.rd_nb[i*DW +: DW] = model_read(a, 1'b0);
      e.rdb[i]            = m_busy[a];
    end
    e.busy      = m_busy;
    e.pc        = m_pc;
    e.lit_rd_en = lit_rd_en;
    e.lit_rd    = lit_rd;
    e.lit_pc_en = lit_pc_en;
    e.lit_pc    = lit_pc;
    lit_rd_en   = 1'b0;
    lit_pc_en   = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    if (!rst) model_update();
    #1;
  endtask

  task automatic idle();
    w_en    = '0;
    sb_set  = 1'b0;
    load_pc = 1'b0;
  endtask

  task automatic wr(input int p, input int a, input logic [DW-1:0] d);
    w_en[p]              = 1'b1;
    w_addr[p*AW +: AW]   = AW'(a);
    w_data[p*DW +: DW]   = d;
  endtask

  task automatic rd(input int i, input int a);
    rd_addr[i*AW +: AW] = AW'(a);
  endtask

  task automatic exp_rd(input logic [DW-1:0] v);
    lit_rd_en = 1'b1;
    lit_rd    = v;
  endtask

  task automatic exp_pc(input logic [PW-1:0] v);
    lit_pc_en = 1'b1;
    lit_pc    = v;
  endtask

  task automatic pcld(input pc_sel_e s);
    load_pc = 1'b1;
    sel_pc  = s;
  endtask

  // Asynchronous reset at posedge+1; the monitor samples at the following
  // negedge, before any clock edge has occurred.
  task automatic do_reset(input string tag);
    idle();
    rst = 1'b1;
    for (int r = 0; r < NR; r++) m_reg[r] = '0;
    m_busy = '0;
    m_pc   = '0;
    step(tag);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({e.tag, ".rd"},    rd_data,    e.rd);
      chk({e.tag, ".rd_nb"}, rd_data_nb, e.rd_nb);
      chk({e.tag, ".rdb"},   {rd_busy_nb, rd_busy}, {e.rdb, e.rdb});
      chk({e.tag, ".busy"},  {busy_nb, busy},       {e.busy, e.busy});
      chk({e.tag, ".pc"},    {pc_out_nb, pc_out},   {e.pc, e.pc});
      if (e.lit_rd_en) chk({e.tag, ".rd0_lit"}, rd_data[DW-1:0], e.lit_rd);
      if (e.lit_pc_en) chk({e.tag, ".pc_lit"},  pc_out,          e.lit_pc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    w_addr   = '0;
    w_data   = '0;
    rd_addr  = '0;
    sb_addr  = '0;
    sel_pc   = PC_HOLD;
    start_pc = '0;
    dp_pc    = '0;
    for (int r = 0; r < NR; r++) m_reg[r] = '0;
    m_busy = '0;
    m_pc   = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    for (int i = 0; i < ND; i++) rd(i, i);
    exp_rd('0); exp_pc('0);
    step("reset_state");

    // Activity then mid-run reset
    idle(); wr(0, 3, 32'h55); sb_set = 1'b1; sb_addr = 4'd4;
    pcld(PC_START); start_pc = 11'h100; rd(0, 3);
    step("pre_rst");
    idle(); rd(0, 3); exp_rd(32'h55); exp_pc(11'h100);
    step("r3_written");
    rd(0, 3); exp_rd('0); exp_pc('0);
    do_reset("mid_rst");

    // R0 is hardwired and ignores writes from every port
    idle(); wr(0, 0, 32'hDEADBEEF); wr(1, 0, 32'hDEADBEEF); wr(2, 0, 32'hDEADBEEF);
    rd(0, 0); exp_rd('0);
    step("r0_wr");
    idle(); rd(0, 0); exp_rd('0);
    step("r0_rd");

    // Collision: highest port wins
    idle(); wr(0, 5, 32'd1); wr(1, 5, 32'd2); wr(2, 5, 32'd3); rd(0, 5); exp_rd(32'd3);
    step("coll_byp");
    idle(); rd(0, 5); exp_rd(32'd3);
    step("coll");

    // Bypass vs no-bypass
    idle(); wr(1, 7, 32'hA5A5A5A5); rd(0, 7); rd(1, 7); exp_rd(32'hA5A5A5A5);
    step("byp");
    idle(); rd(0, 7); exp_rd(32'hA5A5A5A5);
    step("byp_after");

    // Scoreboard
    idle(); sb_set = 1'b1; sb_addr = 4'd9; rd(0, 9);
    step("sb_set");
    idle(); rd(0, 9);
    step("sb_busy");
    idle(); wr(2, 9, 32'h12345678); rd(0, 9); exp_rd(32'h12345678);
    step("ldr_clr");
    idle(); rd(0, 9); exp_rd(32'h12345678);
    step("ldr_done");
    idle(); sb_set = 1'b1; sb_addr = 4'd9; wr(2, 9, 32'hCAFE0001);
    step("set_clr");
    idle(); rd(0, 9);
    step("set_wins");

    // PC sequencing
    idle(); pcld(PC_START); start_pc = 11'h100;
    step("pc_start");
    exp_pc(11'h100); pcld(PC_INC);
    step("pc_inc1");
    step("pc_inc2");
    step("pc_inc3");
    idle(); exp_pc(11'h103);
    step("pc_hold0");
    exp_pc(11'h103); pcld(PC_HOLD);
    step("pc_hold1");
    exp_pc(11'h103); pcld(PC_DP); dp_pc = 11'h7FF;
    step("pc_dp");
    exp_pc(11'h7FF); pcld(PC_INC);
    step("pc_wrap");
    idle(); exp_pc(11'h000);
    step("pc_zero");

    // PC alias on R15
    idle(); pcld(PC_DP); dp_pc = 11'h042;
    step("alias_ld");
    idle(); rd(0, 15); wr(0, 15, 32'hFFFFFFFF); exp_rd(32'h42);
    step("alias_wr");
    idle(); rd(0, 15); exp_rd(32'h42);
    step("alias_rd");

    // Randomised traffic with occasional asynchronous resets
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < NW; p++) begin
        w_en[p] = ($urandom_range(0, 2) == 0);
        w_addr[p*AW +: AW] = AW'($urandom_range(0, NR - 1));
        w_data[p*DW +: DW] = $urandom;
      end
      for (int i = 0; i < ND; i++) rd(i, int'($urandom_range(0, NR - 1)));
      sb_set   = ($urandom_range(0, 3) == 0);
      sb_addr  = AW'($urandom_range(0, NR - 1));
      load_pc  = ($urandom_range(0, 1) == 1);
      sel_pc   = 2'($urandom_range(0, 3));
      start_pc = PW'($urandom);
      dp_pc    = PW'($urandom);
      if ($urandom_range(0, 63) == 0) do_reset("rand_rst");
      else step("rand");
    end

    idle();
    step("drain");
    repeat (2) @(negedge clk);
    chk("queue_empty", 160'(exp_q.size()), 160'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the pipelined ARM32 core. It replaces the fixed three-write/five-read register file with configurable width, depth and port counts. It adds optional write-to-read bypass, a load-pending scoreboard that flags read hazards, and an integrated program counter with a selectable next-PC source. It sits between decode (read ports), writeback/LDR return (write ports) and fetch (PC).

## Interface
- DATA_W, 32, register width in bits
- NREGS, 16, number of architectural registers (power of two, ≥4); AW = $clog2(NREGS)
- NWR, 3, write ports; port NWR-1 is the LDR return port
- NRD, 5, read ports
- PC_W, 11, program counter width
- ZERO_R0, 1, R0 reads zero and ignores writes
- BYPASS, 1, same-cycle write data forwarded to reads
- PC_ALIAS, 1, reads of register NREGS-1 return the zero-extended PC; writes to it are ignored

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- w_en  in  NWR  per-port write enable
- w_addr  in  NWR×AW  write addresses
- w_data  in  NWR×DATA_W  write data
- rd_addr  in  NRD×AW  read addresses
- rd_data  out  NRD×DATA_W  read data, combinational
- rd_busy  out  NRD  read address has a load pending
- sb_set  in  1  mark register sb_addr as load-pending
- sb_addr  in  AW  scoreboard set address
- busy  out  NREGS  scoreboard vector
- load_pc  in  1  update PC this cycle
- sel_pc  in  2  next-PC source, pc_sel_e
- start_pc  in  PC_W  start/reset-vector address
- dp_pc  in  PC_W  branch target from the datapath
- pc_out  out  PC_W  current PC

## Operation
- Write: on the rising edge, each port with w_en=1 writes w_data to w_addr.
- Write collision (same address, multiple ports enabled): the highest port index wins, so LDR beats the others.
- Writes to R0 are dropped when ZERO_R0=1. Writes to R(NREGS-1) are dropped when PC_ALIAS=1.
- Read: rd_data[i] = reg[rd_addr[i]], purely combinational.
- Read of R0 with ZERO_R0=1 returns 0.
- Read of R(NREGS-1) with PC_ALIAS=1 returns {0, pc_out}.
- BYPASS=1: if any enabled write port targets rd_addr[i] this cycle (and the address is writable), rd_data[i] returns the winning port's w_data. BYPASS=0: reads return the pre-edge value.
- Scoreboard:
  - sb_set=1 sets busy[sb_addr] at the edge.
  - An LDR-port write (w_en[NWR-1]) clears busy[w_addr[NWR-1]].
  - Set and clear on the same address in the same cycle: set wins.
  - busy[0] is always 0 when ZERO_R0=1.
  - rd_busy[i] = busy[rd_addr[i]]. It is not bypassed: a same-cycle LDR clear still reads busy.
- PC: when load_pc=1 the PC updates from sel_pc:
  - PC_INC: pc+1, modulo 2^PC_W (wraps to 0)
  - PC_DP: dp_pc
  - PC_START: start_pc
  - PC_HOLD: unchanged
- When load_pc=0 the PC holds.

## Timing
- Reset (asynchronous assert, synchronous release at clk): all registers, busy, and pc_out = 0.
- Outputs settle combinationally from reset state; rd_data = 0 and rd_busy = 0.
- Write-to-read latency: 0 cycles with BYPASS=1; 1 cycle (visible after the edge) with BYPASS=0.
- sb_set to busy/rd_busy: 1 cycle. LDR write to busy clear: 1 cycle.
- PC: load_pc sampled at the edge; pc_out changes after that edge.
- rst asserted mid-operation: state clears immediately regardless of enables; writes in that cycle are lost.

## Structure
- Package regfile_pkg holds:
  - enum pc_sel_e {PC_INC=2'd0, PC_DP=2'd1, PC_START=2'd2, PC_HOLD=2'd3}
  - function f_aw(nregs) returning the address width
- Sub-module regfile_scoreboard(NREGS, AW, ZERO_R0) owns the busy vector and its set/clear/priority logic. The top instantiates it once.
- Storage is a flop array; no memory macro. Read muxes, bypass and PC logic live in the top.

## Test plan
- Reset: assert rst mid-run after writing R3=0x55 → R3 reads 0, pc_out=0, busy=0 immediately, with no clock edge.
- R0 and collision:
  - w_en={1,1,1} all to R0 with 0xDEADBEEF → R0 reads 0.
  - All ports to R5 with data 1/2/3 → R5=3.
- Bypass: BYPASS=1, write R7=0xA5A5A5A5 and read R7 on the same cycle → rd_data=0xA5A5A5A5 before the edge. BYPASS=0 build → old value until after the edge.
- Scoreboard:
  - sb_set R9 → busy[9]=1 next cycle.
  - LDR write R9=0x12345678 → busy[9]=0 next cycle and R9 reads 0x12345678.
  - sb_set R9 together with an LDR write to R9 → busy[9] stays 1.
- PC sequencing:
  - PC_START with start_pc=0x100 → 0x100.
  - PC_INC ×3 → 0x103.
  - load_pc=0 → holds.
  - PC_DP with dp_pc=0x7FF, then PC_INC → 0x000 (wrap).
- PC alias: PC_ALIAS=1, pc=0x042 → read R15 returns 0x00000042. A write to R15 is ignored.
